rx_core: RTL
============

# rx_core

Parametrised successor UART receive engine, sitting between the line synchroniser and the Rx FIFO/register interface. Oversamples the synchronised line on each baud tick, majority-votes three mid-bit samples, and supports 5–9 data bits, even/odd/mark parity and 1 or 2 stop bits. Detects parity, framing and break conditions, and delivers each frame through a one-entry valid/ready holding register with sticky overrun reporting.

## Interface
Parameters:
- MAX_UART_DATA_W, 9, width of the data output; legal values are 5–9.
- SAMPLE_COUNT_W, 4, width of the sample counter; oversample ratio OSR = 2**SAMPLE_COUNT_W, minimum 8.
- TOTAL_CONF_W, 6, width of the configuration field: {data_code[2:0], parity_mode[1:0], stop2}.

Ports:
- clk_i  in  1  top clock; only clock.
- rst_i  in  1  synchronous, active-high reset.
- baud_en_i  in  1  oversample tick, one clk_i pulse per 1/OSR bit period.
- rx_en_i  in  1  receiver enable.
- uart_rx_i  in  1  already-synchronised Rx line.
- rx_conf_i  in  TOTAL_CONF_W  configuration.
- rx_ready_i  in  1  consumer ready.
- clr_overrun_i  in  1  clears the sticky overrun flag.
- rx_valid_o  out  1  holding register full.
- rx_data_o  out  MAX_UART_DATA_W  received data, LSB first on the line, zero-extended above the configured width.
- rx_parity_err_o  out  1  per-frame flag, qualified by rx_valid_o.
- rx_frame_err_o  out  1  per-frame flag, qualified by rx_valid_o.
- rx_break_o  out  1  per-frame flag, qualified by rx_valid_o.
- rx_overrun_o  out  1  sticky overrun flag.
- rx_busy_o  out  1  frame in progress.

## Operation
Configuration decode:
- Data bits = 5 + data_code.
- If data_code > MAX_UART_DATA_W-5, the width clamps to MAX_UART_DATA_W.
- parity_mode: 00 none, 01 even, 10 odd, 11 mark (expected value 1).
- stop2 = 1 selects 2 stop bits.
- rx_conf_i is latched on the Idle->Start transition and held for the whole frame.

State machine (advances only on baud_en_i):
- Idle -> Start when rx_en_i=1 and uart_rx_i=0. The sample counter is cleared on this transition.
- Start: the vote is taken at count MID+1, where MID = OSR/2-1.
  - Vote = 1 -> Idle (false start, nothing delivered).
  - Vote = 0 -> Data at count OSR-1.
- Data: one bit per OSR ticks, voted into bit index data_cnt. After the last bit -> Parity if parity is enabled, otherwise -> Stop.
- Parity: one bit period -> Stop.
- Stop: one or two bit periods.
  - The frame completes at the vote point (count MID+1) of the last stop bit.
  - The FSM returns directly to Idle on that tick, giving half-bit resynchronisation for back-to-back frames.
- rx_en_i=0 in any non-Idle state -> Idle on the next tick. The partial frame is discarded and no flags are set.

Sampling:
- Samples are taken at counts MID-1, MID and MID+1.
- Bit value = majority of the three samples.

Error and status flags:
- Parity error: the voted parity bit differs from the expected value (even: XOR of the data; odd: its inverse; mark: 1).
- Framing error: any voted stop bit is 0.
- Break: all data bits, the parity bit (if present) and the first stop bit vote 0. Break implies framing error.
- rx_busy_o = 1 in Start, Data, Parity and Stop.

Delivery:
- At frame completion, if the holding register is empty or is handshaking in the same cycle (rx_valid_o & rx_ready_i), data and flags load and rx_valid_o = 1.
- Otherwise the new frame is dropped, held contents are unchanged, and rx_overrun_o is set.
- Handshake without a new frame: rx_valid_o clears the next cycle.
- rx_overrun_o clears on clr_overrun_i. A set in the same cycle wins over the clear.

## Timing
- Reset values: every output 0, FSM in Idle, all counters 0, latched configuration 0.
- rx_valid_o and flags are registered and assert one clk_i after the completing baud tick.
- rx_busy_o rises one clk_i after the Idle->Start tick and falls one clk_i after the completing tick.
- Data, flags and rx_valid_o change only on a load or a handshake.
- Reset mid-frame: Idle next cycle, rx_valid_o = 0, held data lost.
- Counter wrap-around: the sample counter wraps OSR-1 -> 0, and the bit counters reset on each state change.

## Test plan
- 8N1 frame 0xA5, OSR=16, ready held at 1 -> rx_data_o=0x0A5, rx_valid_o high for 1 clk, all flags 0.
- 9-bit even parity, data 0x1FF, parity sent as 0 -> data 0x1FF, rx_parity_err_o=1.
- 0-glitch lasting 4 ticks on an idle line -> no rx_busy_o after the vote, FSM back in Idle, no rx_valid_o.
- A single corrupted sample at count MID on each data bit of 0x3C -> majority vote still yields 0x3C.
- Line held low for 12 bit periods, 8N1 -> data 0x00, rx_break_o=1, rx_frame_err_o=1.
- Two frames 0x11 and 0x22, ready held at 0 -> first frame held, 0x22 dropped, rx_overrun_o=1 until clr_overrun_i. A subsequent handshake delivers nothing new.

Source files
------------

// File: rtl/rx_core.sv
// UART receive engine: oversampled start detection, 3-sample majority voting,
// 5-9 data bits, optional parity, 1/2 stop bits, one-entry valid/ready output.
module rx_core #(
  parameter int MAX_UART_DATA_W = 9,
  parameter int SAMPLE_COUNT_W  = 4,
  parameter int TOTAL_CONF_W    = 6
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       baud_en_i,
  input  logic                       rx_en_i,
  input  logic                       uart_rx_i,
  input  logic [TOTAL_CONF_W-1:0]    rx_conf_i,
  input  logic                       rx_ready_i,
  input  logic                       clr_overrun_i,
  output logic                       rx_valid_o,
  output logic [MAX_UART_DATA_W-1:0] rx_data_o,
  output logic                       rx_parity_err_o,
  output logic                       rx_frame_err_o,
  output logic                       rx_break_o,
  output logic                       rx_overrun_o,
  output logic                       rx_busy_o
);

  localparam int OSR    = 1 << SAMPLE_COUNT_W;
  localparam int DCNT_W = $clog2(MAX_UART_DATA_W);
  localparam logic [SAMPLE_COUNT_W-1:0] SMP_A = SAMPLE_COUNT_W'(OSR / 2 - 2);
  localparam logic [SAMPLE_COUNT_W-1:0] SMP_B = SAMPLE_COUNT_W'(OSR / 2 - 1);
  localparam logic [SAMPLE_COUNT_W-1:0] SMP_V = SAMPLE_COUNT_W'(OSR / 2);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
  } state_t;

  state_t state_q, state_d;

  logic [TOTAL_CONF_W-1:0]    conf_q;
  logic [2:0]                 data_code;
  logic [1:0]                 parity_mode;
  logic                       stop2;
  logic [DCNT_W-1:0]          last_idx;
  logic [SAMPLE_COUNT_W-1:0]  cnt_q;
  logic [DCNT_W-1:0]          data_cnt_q;
  logic                       stop_cnt_q;
  logic [1:0]                 samp_q;
  logic [MAX_UART_DATA_W-1:0] data_sh_q;
  logic                       par_acc_q, par_err_q, frm_err_q, zero_q;
  logic                       vote, at_vote, bit_end, last_data, last_stop;
  logic                       frame_done, par_exp, fin_brk, fin_frm;
  logic [MAX_UART_DATA_W-1:0] fin_data;

  assign data_code   = conf_q[5:3];
  assign parity_mode = conf_q[2:1];
  assign stop2       = conf_q[0];

  always_comb begin
    if (int'(data_code) > MAX_UART_DATA_W - 5) last_idx = DCNT_W'(MAX_UART_DATA_W - 1);
    else                                       last_idx = DCNT_W'(int'(data_code) + 4);
  end

  always_comb begin
    case (parity_mode)
      2'b01:   par_exp = par_acc_q;
      2'b10:   par_exp = ~par_acc_q;
      default: par_exp = 1'b1;
    endcase
  end

  assign vote       = (samp_q[0] & samp_q[1]) | (samp_q[0] & uart_rx_i) | (samp_q[1] & uart_rx_i);
  assign at_vote    = (cnt_q == SMP_V);
  assign bit_end    = (cnt_q == '1);
  assign last_data  = (data_cnt_q == last_idx);
  assign last_stop  = (stop_cnt_q == stop2);
  assign frame_done = baud_en_i & rx_en_i & (state_q == ST_STOP) & at_vote & last_stop;

  // Bits were shifted in from the top, so narrow frames sit left-aligned.
  assign fin_data = data_sh_q >> (DCNT_W'(MAX_UART_DATA_W - 1) - last_idx);
  assign fin_brk  = zero_q & (stop_cnt_q | ~vote);
  assign fin_frm  = frm_err_q | ~vote;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (baud_en_i) begin
      if (state_q == ST_IDLE) begin
        if (rx_en_i && !uart_rx_i) state_d = ST_START;
      end else if (!rx_en_i) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_START:  if (at_vote && vote) state_d = ST_IDLE;
                     else if (bit_end)    state_d = ST_DATA;
          ST_DATA:   if (bit_end && last_data)
                       state_d = (parity_mode != 2'b00) ? ST_PARITY : ST_STOP;
          ST_PARITY: if (bit_end) state_d = ST_STOP;
          ST_STOP:   if (at_vote && last_stop) state_d = ST_IDLE;
          default:   state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    rx_busy_o = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conf_q     <= '0;
      cnt_q      <= '0;
      data_cnt_q <= '0;
      stop_cnt_q <= 1'b0;
      samp_q     <= '0;
      data_sh_q  <= '0;
      par_acc_q  <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      zero_q     <= 1'b0;
    end else if (baud_en_i) begin
      cnt_q <= (state_q == ST_IDLE || state_d == ST_IDLE) ? '0 : cnt_q + 1'b1;
      if (state_d != state_q) begin
        data_cnt_q <= '0;
        stop_cnt_q <= 1'b0;
      end else begin
        if (state_q == ST_DATA && bit_end) data_cnt_q <= data_cnt_q + 1'b1;
        if (state_q == ST_STOP && bit_end) stop_cnt_q <= 1'b1;
      end
      if (cnt_q == SMP_A) samp_q[0] <= uart_rx_i;
      if (cnt_q == SMP_B) samp_q[1] <= uart_rx_i;
      if (state_q == ST_IDLE && state_d == ST_START) begin
        conf_q    <= rx_conf_i;
        data_sh_q <= '0;
        par_acc_q <= 1'b0;
        par_err_q <= 1'b0;
        frm_err_q <= 1'b0;
        zero_q    <= 1'b1;
      end else if (at_vote) begin
        case (state_q)
          ST_DATA: begin
            data_sh_q <= {vote, data_sh_q[MAX_UART_DATA_W-1:1]};
            par_acc_q <= par_acc_q ^ vote;
            zero_q    <= zero_q & ~vote;
          end
          ST_PARITY: begin
            par_err_q <= (vote != par_exp);
            zero_q    <= zero_q & ~vote;
          end
          ST_STOP: begin
            if (!vote)       frm_err_q <= 1'b1;
            if (!stop_cnt_q) zero_q    <= zero_q & ~vote;
          end
          default: ;
        endcase
      end
    end
  end

  // Holding register: a frame loads if the slot is free or being drained this cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_valid_o      <= 1'b0;
      rx_data_o       <= '0;
      rx_parity_err_o <= 1'b0;
      rx_frame_err_o  <= 1'b0;
      rx_break_o      <= 1'b0;
      rx_overrun_o    <= 1'b0;
    end else begin
      if (frame_done && (!rx_valid_o || rx_ready_i)) begin
        rx_valid_o      <= 1'b1;
        rx_data_o       <= fin_data;
        rx_parity_err_o <= par_err_q;
        rx_frame_err_o  <= fin_frm;
        rx_break_o      <= fin_brk;
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
      if (frame_done && rx_valid_o && !rx_ready_i) rx_overrun_o <= 1'b1;
      else if (clr_overrun_i)                      rx_overrun_o <= 1'b0;
    end
  end

endmodule
